shift_counter_ctrl: RTL and testbench
=====================================

Name: shift_counter_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit twisted-ring (Johnson) or ring shift counter. The counter register is held inside the block.
- A requester issues one command (mode, direction, step count) through a valid/ready handshake. The block seeds the counter, advances it exactly N steps (pausable and abortable), then pulses done.
- Sits between the control logic and the counter datapath. It replaces the free-running counter, which could only be reset.

Parameters:
WIDTH, 4, counter width in bits (≥2)
CNT_W, 8, width of step-count field

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 clears the block immediately)
cmd_valid  in  1  command present
cmd_ready  out  1  block accepts a command (high only in IDLE)
cmd_mode  in  1  0 = Johnson, 1 = ring
cmd_dir  in  1  0 = shift left, 1 = shift right
cmd_steps  in  CNT_W  number of shifts to perform
pause  in  1  hold counter while high (RUN only)
abort  in  1  cancel current command
q  out  WIDTH  counter value (registered)
busy  out  1  high in LOAD/RUN
done  out  1  one-cycle pulse on completion
steps_left  out  CNT_W  remaining shifts (registered)
err  out  1  sticky illegal-pattern flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state=IDLE, q=0, cmd_ready=1, busy=0, done=0, steps_left=0, err=0.
- States: IDLE, LOAD, RUN, DONE.
  - IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready; latch mode, dir, steps. Go to LOAD.
  - LOAD: one cycle. q <= seed, steps_left <= latched steps. Seed is 0 for Johnson and 1 (LSB set) for ring. Go to RUN if steps≠0, else DONE.
  - RUN: per edge, evaluated in priority order:
    - abort → IDLE; q holds; steps_left <= 0; no done.
    - pause → q and steps_left hold.
    - otherwise shift q and decrement steps_left. Go to DONE when steps_left was 1.
  - DONE: done=1 for exactly this cycle; q holds final value. Go to IDLE.
- Shift rules:
  - Johnson left: q <= {q[W-2:0], ~q[W-1]}. Johnson right: q <= {~q[0], q[W-1:1]}.
  - Ring left: q <= {q[W-2:0], q[W-1]}. Ring right: q <= {q[0], q[W-1:1]}.
  - Johnson period is 2·WIDTH; ring period is WIDTH. Wrap-around is natural (no special case).
- Latency (no pause, accept at edge 0):
  - Edge 1: seed loaded.
  - Edges 2..N+1: shifts.
  - done high in the cycle after edge N+1.
  - cmd_ready high again after edge N+2.
  - N=0: done in the cycle after edge 1, with q = seed.
- Other rules:
  - abort in LOAD acts as in RUN: goes to IDLE, and the seed is still loaded.
  - abort and pause are ignored in IDLE and DONE.
  - cmd_valid while busy is ignored; the command is neither latched nor acknowledged.
  - cmd_steps is sampled only at acceptance.
  - A new command may be presented in the same cycle cmd_ready rises.

Optional Feature:
- Macro: ILLEGAL_STATE_CHECK_EN.
- Defined: in RUN (not paused, not aborted), q is checked before each shift.
  - Johnson: legal iff popcount(q ^ rotate_left(q)) ≤ 2.
  - Ring: legal iff exactly one bit set.
  - If illegal: q <= seed instead of shifting, steps_left not decremented, err <= 1.
  - err stays set until the next command acceptance or reset.
- Undefined: no check; err tied to 0.

Test Plan:
- Reset → Johnson, left, 8 steps: q = 0000 at edge 1, then 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. done pulses after edge 9; busy falls; cmd_ready returns after edge 10.
- Ring, right, 5 steps: seed 0001, then 1000, 0100, 0010, 0001, 1000. Final q = 1000; steps_left = 0; one done pulse.
- Johnson, left, 4 steps; pause high for 3 cycles after the 2nd shift: q holds 0011 and steps_left holds 2. Resumes to 0111, 1111; done is 3 cycles later than unpaused.
- Ring, left, 10 steps; abort after 3 shifts: IDLE next cycle; q holds 1000; steps_left = 0; no done pulse. Also: cmd_valid during RUN is ignored. steps=0 command: q = 0001 (ring) or 0000 (Johnson); done after edge 1.
- Async reset pulse mid-RUN between clock edges: all outputs 0 immediately. After release, block accepts a new command normally.
- With ILLEGAL_STATE_CHECK_EN: force q = 0101 in Johnson RUN. Next edge q = 0000, err = 1, steps_left unchanged. err clears on the next accepted command.

Source files
------------

// File: rtl/shift_counter_ctrl.sv
// shift_counter_ctrl: command-driven sequencer for a WIDTH-bit Johnson or ring
// shift counter. A command (mode, dir, steps) is accepted in IDLE, the counter
// is seeded in LOAD, advanced steps times in RUN (pausable/abortable), and DONE
// pulses for one cycle.
// Optional macro: ILLEGAL_STATE_CHECK_EN -- checks the counter pattern before
// every shift, reseeds on an illegal pattern and raises the sticky err flag.
module shift_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] sl_q, sl_d;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] shifted;

  // Ring starts with a single one in the LSB; Johnson starts all-zero.
  assign seed = {{(WIDTH-1){1'b0}}, mode_q};

  // One shift of the counter in the latched mode and direction.
  always_comb begin
    shifted = q_q;
    case ({mode_q, dir_q})
      2'b00:   shifted = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      2'b01:   shifted = {~q_q[0], q_q[WIDTH-1:1]};
      2'b10:   shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      default: shifted = {q_q[0], q_q[WIDTH-1:1]};
    endcase
  end

`ifdef ILLEGAL_STATE_CHECK_EN
  logic             err_q, err_d;
  logic [WIDTH-1:0] edges;
  logic             legal;

  // A Johnson pattern has at most two 0/1 boundaries around the ring; a ring
  // pattern is one-hot.
  assign edges = q_q ^ {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign legal = mode_q ? ($countones(q_q) == 1) : ($countones(edges) <= 2);
  assign err   = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state, datapath and command-latch logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    q_d     = q_q;
    sl_d    = sl_q;
`ifdef ILLEGAL_STATE_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          dir_d   = cmd_dir;
          steps_d = cmd_steps;
`ifdef ILLEGAL_STATE_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The seed lands even when the command is aborted here.
        q_d = seed;
        if (abort) begin
          sl_d    = '0;
          state_d = IDLE;
        end else begin
          sl_d    = steps_q;
          state_d = (steps_q != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          sl_d    = '0;
          state_d = IDLE;
        end else if (!pause) begin
`ifdef ILLEGAL_STATE_CHECK_EN
          if (!legal) begin
            // Corrupted pattern: restart from the seed without using a step.
            q_d   = seed;
            err_d = 1'b1;
          end else begin
            q_d  = shifted;
            sl_d = sl_q - CNT_W'(1);
            if (sl_q == CNT_W'(1)) state_d = DONE;
          end
`else
          q_d  = shifted;
          sl_d = sl_q - CNT_W'(1);
          if (sl_q == CNT_W'(1)) state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      steps_q <= '0;
      q_q     <= '0;
      sl_q    <= '0;
`ifdef ILLEGAL_STATE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      q_q     <= q_d;
      sl_q    <= sl_d;
`ifdef ILLEGAL_STATE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign done       = (state_q == DONE);
  assign q          = q_q;
  assign steps_left = sl_q;

endmodule

// File: tb/tb_shift_counter_ctrl.sv
// Bench for shift_counter_ctrl: directed commands with literal expectations,
// plus a per-cycle compare against a model that derives the counter value
// from the number of completed shifts.
module tb_shift_counter_ctrl;
  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0, cmd_mode = 1'b0, cmd_dir = 1'b0;
  logic [C-1:0] cmd_steps = '0;
  logic         pause = 1'b0, abort = 1'b0;
  logic         cmd_ready, busy, done, err;
  logic [W-1:0] q;
  logic [C-1:0] steps_left;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b1;

  shift_counter_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .pause(pause), .abort(abort), .q(q), .busy(busy), .done(done),
    .steps_left(steps_left), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Counter value after k shifts from the seed, from the pattern shape.
  function automatic logic [W-1:0] pat(input logic m, input logic d, input int k);
    int kk, ones;
    if (m) begin
      kk = k % W;
      return d ? W'(1 << ((W - kk) % W)) : W'(1 << kk);
    end
    kk = k % (2 * W);
    if (kk <= W) begin
      ones = (1 << kk) - 1;
      return d ? W'(ones << (W - kk)) : W'(ones);
    end
    ones = d ? (1 << (2 * W - kk)) - 1 : ((1 << W) - 1) << (kk - W);
    return W'(ones);
  endfunction

  // Model: e counts non-paused edges since acceptance (0 = seed pending,
  // 1..N = shifting, N+1 = done cycle).
  bit           m_act = 1'b0;
  int           e = 0, mN = 0;
  logic         mm = 1'b0, md = 1'b0;
  logic [W-1:0] mq = '0;
  logic [C-1:0] msl = '0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_act = 1'b0; mq = '0; msl = '0;
    end else if (!m_act) begin
      if (cmd_valid) begin
        m_act = 1'b1; e = 0; mN = int'(cmd_steps); mm = cmd_mode; md = cmd_dir;
      end
    end else if (e <= mN) begin
      if (abort) begin
        if (e == 0) mq = pat(mm, md, 0);
        msl = '0;
        m_act = 1'b0;
      end else if (!(e >= 1 && pause)) begin
        e++;
        mq  = pat(mm, md, e - 1);
        msl = C'(mN - (e - 1));
      end
    end else begin
      m_act = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1 && chk_en)
      chk("cycle{q,sl,busy,done,rdy,err}",
          32'({q, steps_left, busy, done, cmd_ready, err}),
          32'({mq, msl, m_act && (e <= mN), m_act && (e == mN + 1), !m_act, 1'b0}));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic m, input logic d, input int n);
    cmd_mode = m; cmd_dir = d; cmd_steps = C'(n); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [W-1:0] jl [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  logic [W-1:0] rr [6] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8};

  initial begin
    #3;
    chk("rst_q", 32'(q), 0);
    chk("rst_ctl{rdy,busy,done,err}", 32'({cmd_ready, busy, done, err}), 32'b1000);
    chk("rst_sl", 32'(steps_left), 0);
    tick();
    reset = 1'b1;
    tick();

    // Johnson left, 8 steps: full period back to zero.
    issue(1'b0, 1'b0, 8);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("j8_q", 32'(q), 32'(jl[k]));
    end
    chk("j8_done_busy", 32'({done, busy}), 32'b10);
    tick();
    chk("j8_rdy_done", 32'({cmd_ready, done}), 32'b10);

    // Ring right, 5 steps.
    issue(1'b1, 1'b1, 5);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("r5_q", 32'(q), 32'(rr[k]));
    end
    chk("r5_done_sl", 32'({done, steps_left}), 32'h100);
    tick();

    // Johnson left 4 with a 3-cycle pause after the second shift.
    issue(1'b0, 1'b0, 4);
    tick(3);
    chk("p_q_before", 32'(q), 32'h3);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("p_hold_q_sl", 32'({q, steps_left}), 32'h302);
    end
    pause = 1'b0;
    tick();
    chk("p_resume1", 32'({q, steps_left}), 32'h701);
    tick();
    chk("p_resume2", 32'({q, steps_left, done}), 32'({4'hF, 8'h00, 1'b1}));
    tick();

    // Ring left 10, stray command during RUN, abort after 3 shifts.
    issue(1'b1, 1'b0, 10);
    tick(2);
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_steps = 8'd3;
    tick();
    chk("a_rdy_low", 32'(cmd_ready), 0);
    tick();
    chk("a_q3", 32'(q), 32'h8);
    cmd_valid = 1'b0;
    abort = 1'b1;
    tick();
    chk("a_idle", 32'({q, steps_left, cmd_ready, done}), 32'({4'h8, 8'h00, 1'b1, 1'b0}));
    abort = 1'b0;
    tick();
    chk("a_hold", 32'({q, busy, done}), 32'({4'h8, 1'b0, 1'b0}));

    // Zero-step commands complete right after the seed load.
    issue(1'b1, 1'b0, 0);
    tick();
    chk("z_ring", 32'({q, done, busy}), 32'({4'h1, 1'b1, 1'b0}));
    tick();
    issue(1'b0, 1'b1, 0);
    tick();
    chk("z_john", 32'({q, done}), 32'({4'h0, 1'b1}));
    tick();

    // Async reset pulse mid-RUN, between edges.
    issue(1'b0, 1'b0, 8);
    tick(3);
    #1 reset = 1'b0;
    #1;
    chk("ar_out", 32'({q, steps_left, busy, done, cmd_ready, err}), 32'b10);
    #2 reset = 1'b1;
    tick();
    issue(1'b1, 1'b0, 2);
    tick(3);
    chk("ar_after", 32'({q, done}), 32'({4'h4, 1'b1}));
    tick();

    // Model-checked sweep, including wrap-around counts.
    for (int k = 0; k < 6; k++) begin
      issue(k[0], k[1], 3 + 4 * k);
      tick(3 + 4 * k + 2);
    end

`ifdef ILLEGAL_STATE_CHECK_EN
    chk_en = 1'b0;
    issue(1'b0, 1'b0, 4);
    tick(2);
    force dut.q_q = 4'b0101;
    #1 release dut.q_q;
    tick();
    chk("ill_q_err_sl", 32'({q, err, steps_left}), 32'({4'h0, 1'b1, 8'h03}));
    tick(3);
    chk("ill_finish", 32'({q, done, err}), 32'({4'h7, 1'b1, 1'b1}));
    tick();
    issue(1'b1, 1'b0, 1);
    chk("ill_err_clr", 32'(err), 0);
    tick(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
